// File: rtl/parity_pkg.sv
// Shared definitions for the parity serial transmitter and its checker:
// frame state encoding, width helper and the parity rule.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    GAP    = 2'd3
  } state_t;

  // Width needed to index n values, never less than one bit.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Even parity is the XOR of the word; odd parity is its complement.
  // Unused upper bits of the word must be zero.
  function automatic logic parity_of(input logic [63:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/parity_tx_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request after the last
// granted index and remembers the winner whenever a grant is taken.
module rr_arbiter
  import parity_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = clog2w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx
);

  logic [IW-1:0] last;
  logic [IW-1:0] cand;
  logic          found;

  // Search last+1, last+2, ... (wrapping) for the first active request.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  // Pointer moves only when the winner is actually accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= IW'(NUM_REQ - 1);
    end else if (advance && found) begin
      last <= grant_idx;
    end
  end

endmodule

// File: rtl/parity_tx_sched.sv
// Shares one serial parity transmitter between NUM_REQ word sources.
// Handshake: a word moves when req_valid[i] & req_ready[i] at posedge clk;
// req_ready is one-hot-or-zero and only opens in IDLE or in the last cycle
// of a frame, so a new frame can follow the previous one without a bubble.
module parity_tx_sched
  import parity_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int NUM_BITS   = 8,
  parameter int GAP_CYCLES = 1,
  parameter int ODD_PARITY = 0,
  localparam int IW = clog2w(NUM_REQ),
  localparam int BW = clog2w(NUM_BITS + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*NUM_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        wr_en,
  output logic                        data_out,
  output logic                        par_bit,
  output logic                        frame_start,
  output logic [IW-1:0]               grant_id,
  output logic                        busy
);

  state_t              state, state_nx;
  logic [BW-1:0]       bit_cnt, bit_cnt_nx;
  logic [7:0]          gap_cnt, gap_cnt_nx;
  logic [NUM_BITS-1:0] shreg, shreg_nx;
  logic                par_acc, par_acc_nx;
  logic                wr_en_nx, data_nx, par_nx, fs_nx, busy_nx;
  logic [IW-1:0]       gid_nx;

  logic [NUM_REQ-1:0]  grant;
  logic [IW-1:0]       grant_idx;
  logic                accept_win;
  logic                handshake;
  logic [NUM_BITS-1:0] word;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .advance   (accept_win),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Accept window: idle, or the final cycle of the current frame.
  always_comb begin
    accept_win = (state == IDLE)
              || ((state == PARITY) && (GAP_CYCLES == 0))
              || ((state == GAP) && (gap_cnt == 8'(GAP_CYCLES)));
    req_ready  = accept_win ? grant : '0;
    handshake  = accept_win && (|grant);
    word       = req_data[int'(grant_idx)*NUM_BITS +: NUM_BITS];
  end

  // Next state and next registered outputs; a handshake always starts a frame.
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    gap_cnt_nx = gap_cnt;
    shreg_nx   = shreg;
    par_acc_nx = par_acc;
    wr_en_nx   = 1'b0;
    data_nx    = 1'b0;
    par_nx     = 1'b0;
    fs_nx      = 1'b0;
    gid_nx     = grant_id;
    if (handshake) begin
      state_nx   = SHIFT;
      bit_cnt_nx = BW'(1);
      shreg_nx   = {word[NUM_BITS-2:0], 1'b0};
      par_acc_nx = parity_of(64'(word), ODD_PARITY != 0);
      wr_en_nx   = 1'b1;
      data_nx    = word[NUM_BITS-1];
      fs_nx      = 1'b1;
      gid_nx     = grant_idx;
    end else begin
      case (state)
        IDLE: begin
          state_nx = IDLE;
        end
        SHIFT: begin
          wr_en_nx = 1'b1;
          if (bit_cnt == BW'(NUM_BITS)) begin
            state_nx = PARITY;
            par_nx   = 1'b1;
            data_nx  = par_acc;
          end else begin
            data_nx    = shreg[NUM_BITS-1];
            shreg_nx   = {shreg[NUM_BITS-2:0], 1'b0};
            bit_cnt_nx = bit_cnt + BW'(1);
          end
        end
        PARITY: begin
          if (GAP_CYCLES == 0) begin
            state_nx = IDLE;
          end else begin
            state_nx   = GAP;
            gap_cnt_nx = 8'd1;
          end
        end
        GAP: begin
          if (gap_cnt == 8'(GAP_CYCLES)) begin
            state_nx = IDLE;
          end else begin
            gap_cnt_nx = gap_cnt + 8'd1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
    busy_nx = (state_nx != IDLE);
  end

  // State, datapath and registered serial outputs; reset aborts any frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      shreg       <= '0;
      par_acc     <= 1'b0;
      wr_en       <= 1'b0;
      data_out    <= 1'b0;
      par_bit     <= 1'b0;
      frame_start <= 1'b0;
      grant_id    <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      bit_cnt     <= bit_cnt_nx;
      gap_cnt     <= gap_cnt_nx;
      shreg       <= shreg_nx;
      par_acc     <= par_acc_nx;
      wr_en       <= wr_en_nx;
      data_out    <= data_nx;
      par_bit     <= par_nx;
      frame_start <= fs_nx;
      grant_id    <= gid_nx;
      busy        <= busy_nx;
    end
  end

endmodule

// File: doc/parity_tx_sched.md
# parity_tx_sched

Round-robin scheduler that shares one serial parity-bit transmitter between NUM_REQ word sources. It accepts one word per frame via valid/ready and shifts it out MSB-first with a `wr_en` qualifier. It appends one parity bit and inserts a programmable idle gap. It sits ahead of the parity checker/receiver and drives the same `wr_en`/`data_out` serial pair.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `NUM_BITS`, 8: data bits per frame, 2..64.
- `GAP_CYCLES`, 1: idle cycles after parity bit, 0..255.
- `ODD_PARITY`, 0: 0 = even parity (`^word`); 1 = odd parity (`~^word`).
- `clk`  in  1  clock; all logic on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester word valid.
- `req_data`  in  NUM_REQ*NUM_BITS  requester i word at bits [i*NUM_BITS +: NUM_BITS].
- `req_ready`  out  NUM_REQ  one-hot-or-zero accept; handshake = valid & ready at posedge.
- `wr_en`  out  1  serial bit valid.
- `data_out`  out  1  serial bit.
- `par_bit`  out  1  high while `data_out` carries the parity bit.
- `frame_start`  out  1  high while `data_out` carries the MSB.
- `grant_id`  out  clog2(NUM_REQ)  index of requester whose frame is being sent; holds after frame.
- `busy`  out  1  state != IDLE.

## Operation
- FSM states:
  - IDLE: outputs quiet.
  - SHIFT: NUM_BITS data cycles.
  - PARITY: 1 cycle.
  - GAP: GAP_CYCLES cycles, skipped when 0.
- Transitions:
  - IDLE → SHIFT on handshake.
  - SHIFT → PARITY after NUM_BITS-th bit.
  - PARITY → GAP, or, when GAP_CYCLES = 0, → SHIFT on handshake, else → IDLE.
  - GAP → SHIFT on handshake in last gap cycle, else → IDLE.
- Arbitration:
  - Round-robin pointer `last` holds the last granted index; reset value NUM_REQ-1, so req 0 has first priority.
  - Winner = first asserted `req_valid` searching last+1, last+2, … mod NUM_REQ.
  - `last` updates only on handshake.
- `req_ready` is combinational from `req_valid`, `last` and state. It asserts for the winner only in IDLE and in the final cycle of a frame (PARITY if GAP_CYCLES = 0, else last GAP cycle). It is zero otherwise.
- Requester rules: `req_valid` must not drop, and `req_data` must stay stable, until handshake. Violation is a bench assertion, not handled by RTL.
- On handshake the word is latched internally; `req_data` is don't-care afterwards.
- Parity is computed over the latched word only.
- Registered `busy` covers SHIFT, PARITY and GAP.

## Timing
- Reset values: `wr_en`, `data_out`, `par_bit`, `frame_start`, `busy` = 0. `grant_id` = 0, state = IDLE, `last` = NUM_REQ-1.
- All serial outputs are registered. Let E be the handshake edge:
  - after E+i, i = 0..NUM_BITS-1: `wr_en`=1, `data_out`=word[NUM_BITS-1-i]; `frame_start`=1 only for i=0.
  - after E+NUM_BITS: `wr_en`=1, `par_bit`=1, `data_out`=parity.
  - after E+NUM_BITS+1 … E+NUM_BITS+GAP_CYCLES: `wr_en`=0, `data_out`=0.
- Earliest next handshake is edge E+NUM_BITS+1+GAP_CYCLES. Frame period is exactly NUM_BITS+1+GAP_CYCLES under continuous demand. With GAP_CYCLES = 0, `wr_en` stays high continuously.
- `grant_id` updates at E, together with the first bit.
- Reset asserted mid-frame: all outputs return to reset values immediately (async); the frame is aborted, the latched word is discarded and is not retried.
- No request is accepted in the cycle `rst_n` deasserts unless `req_valid` is already high; the first handshake can occur at the first posedge after release.

## Structure
- Shared package `parity_pkg`:
  - state enum (IDLE, SHIFT, PARITY, GAP);
  - clog2-based width function for `grant_id` and the bit counter;
  - parity-function helper shared with the checker.
- Sub-module `rr_arbiter`: parameter NUM_REQ; inputs `req`, `advance`; outputs one-hot `grant` and `grant_idx`; owns the `last` pointer.
- Top holds the FSM, bit counter (width clog2(NUM_BITS+1)), gap counter (8 bits), shift register and parity accumulator.

## Test plan
- NUM_BITS=8, GAP=1, req0 sends 0xA5 → `data_out` 1,0,1,0,0,1,0,1 with `wr_en`=1, then parity 0 (`par_bit`=1), then 1 gap cycle with `wr_en`=0; `frame_start` on first bit only.
- All 4 requesters valid continuously, GAP=0 → grants 0,1,2,3,0; `wr_en` never drops; each frame is 9 cycles.
- Only req2 and req3 valid after req3 was last granted → grant req2 next, then req3; `req_ready` never two-hot.
- ODD_PARITY=1, word 0x00 → parity bit 1; word 0xFF → parity bit 1.
- `rst_n` pulsed low at bit 4 of a frame → all outputs 0 asynchronously; after release, the next valid requester starts from req0 priority with a full new frame.
- GAP=3, req1 valid throughout → successive `frame_start` pulses exactly 12 cycles apart; `req_ready[1]` high only in the last gap cycle.
